hub75_scan_driver: RTL

- Drives a 64x32 HUB75 RGB LED panel at 1/16 scan.
- Acts as the requesting side of the pixel-source interface: issues `{row, col}` pixel addresses and consumes the returned 24-bit RGB data.
- Shifts two rows at a time (upper half and lower half) into the panel, latches them, and sets brightness by 4-plane binary-coded modulation of the 4 MSBs of each colour channel.
- Sits between `temp_pixel_generator` (or any pixel source) and the panel connector pins.

---
 rtl/hub75_pkg.sv | 29 ++
 rtl/hub75_oe_timer.sv | 24 ++
 rtl/hub75_scan_driver.sv | 132 +++++++++++++
 3 files changed

// File: rtl/hub75_pkg.sv
// hub75_pkg: shared geometry, FSM states and pixel bit-plane helper for the HUB75 scan driver
package hub75_pkg;
    localparam int COLS      = 64;
    localparam int ROWS      = 32;
    localparam int SCAN_ROWS = ROWS / 2;
    localparam int COL_W     = $clog2(COLS);
    localparam int ROW_W     = $clog2(SCAN_ROWS);
    // Bit position of plane 0 (the lowest of the 4 MSBs) inside {R,G,B}
    localparam int R_LSB = 20;
    localparam int G_LSB = 12;
    localparam int B_LSB = 4;

    typedef enum logic [2:0] {
        S_FETCH_T,
        S_FETCH_B,
        S_DATA,
        S_CLK,
        S_BLANK,
        S_LATCH,
        S_DISPLAY
    } state_e;

    // msn = {R[7:4], G[7:4], B[7:4]}; returns {r, g, b} for bit-plane p
    function automatic logic [2:0] plane_bits(input logic [11:0] msn, input logic [1:0] p);
        logic [3:0] r, g, b;
        {r, g, b} = msn;
        return {r[p], g[p], b[p]};
    endfunction
endpackage

// File: rtl/hub75_oe_timer.sv
// hub75_oe_timer: loadable down-counter timing the lit period of one bit-plane
// Ports: clk, rst (async active-low); load_i starts a window of BASE_OE<<plane_i
// cycles; done_o is high in the last cycle of that window.
module hub75_oe_timer #(
    parameter int BASE_OE = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [1:0] plane_i,
    output logic       done_o
);
    localparam int W = $clog2(BASE_OE * 8 + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = load_i ? W'(BASE_OE) << plane_i : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);

    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;

    assign done_o = cnt_q == W'(1);
endmodule

// File: rtl/hub75_scan_driver.sv
// hub75_scan_driver: 64x32 HUB75 panel driver, 1/16 scan, 4-plane binary-coded modulation
// Ports: clk, rst (async active-low); pixel_addr/pixel_data request the {row,col}
// pixel and take back 24-bit RGB; panel_r1..b2 colour pins, row_sel A-D,
// panel_clk shift clock, panel_lat latch, panel_oe_n enable, frame_start pulse.
module hub75_scan_driver
    import hub75_pkg::*;
#(
    parameter int BASE_OE = 32
) (
    input  logic        clk,
    input  logic        rst,
    output logic [11:0] pixel_addr,
    input  logic [23:0] pixel_data,
    output logic        panel_r1,
    output logic        panel_g1,
    output logic        panel_b1,
    output logic        panel_r2,
    output logic        panel_g2,
    output logic        panel_b2,
    output logic [3:0]  row_sel,
    output logic        panel_clk,
    output logic        panel_lat,
    output logic        panel_oe_n,
    output logic        frame_start
);
    state_e           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d, row_sel_q, row_sel_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [1:0]       plane_q, plane_d;
    logic [2:0]       up_q, up_d, rgb1_q, rgb1_d, rgb2_q, rgb2_d;
    logic [11:0]      addr_q, addr_d;
    logic             pclk_q, pclk_d, lat_q, lat_d, oe_n_q, oe_n_d, fs_q, fs_d;
    logic             oe_done;
    logic [11:0]      msn;
    logic             unused_lsbs;

    assign msn         = {pixel_data[R_LSB+:4], pixel_data[G_LSB+:4], pixel_data[B_LSB+:4]};
    assign unused_lsbs = ^{pixel_data[19:16], pixel_data[11:8], pixel_data[3:0]};

    hub75_oe_timer #(.BASE_OE(BASE_OE)) u_oe_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (state_q == S_LATCH),
        .plane_i(plane_q),
        .done_o (oe_done)
    );

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        plane_d = plane_q;
        up_d    = up_q;
        rgb1_d  = rgb1_q;
        rgb2_d  = rgb2_q;
        case (state_q)
            S_FETCH_T: state_d = S_FETCH_B;
            S_FETCH_B: begin
                up_d    = plane_bits(msn, plane_q);
                state_d = S_DATA;
            end
            S_DATA: begin
                rgb1_d  = up_q;
                rgb2_d  = plane_bits(msn, plane_q);
                state_d = S_CLK;
            end
            S_CLK: begin
                col_d   = col_q == COL_W'(COLS - 1) ? '0 : col_q + COL_W'(1);
                state_d = col_q == COL_W'(COLS - 1) ? S_BLANK : S_FETCH_T;
            end
            S_BLANK:   state_d = S_LATCH;
            S_LATCH:   state_d = S_DISPLAY;
            S_DISPLAY: if (oe_done) begin
                plane_d = plane_q + 2'd1;
                row_d   = plane_q == 2'd3 ? row_q + ROW_W'(1) : row_q;
                state_d = S_FETCH_T;
            end
            default:   state_d = S_FETCH_T;
        endcase
        // Pin registers are loaded from the state being entered, so each pin is valid
        // during its own state; the lower-half row is row+16 formed in 5 bits.
        addr_d    = state_d == S_FETCH_T ? {1'b0, {1'b0, row_d}, col_d} :
                    state_d == S_FETCH_B ? {1'b0, {1'b0, row_q} + 5'(SCAN_ROWS), col_q} : addr_q;
        lat_d     = state_d == S_LATCH;
        oe_n_d    = state_d != S_DISPLAY;
        row_sel_d = state_d == S_LATCH ? row_q : row_sel_q;
        fs_d      = state_d == S_LATCH && row_q == '0 && plane_q == 2'd0;
        // Colour changes on entry to S_CLK, so the shift clock rises one cycle later
        // with a full cycle of setup and stays stable for three cycles of hold.
        pclk_d    = state_q == S_CLK;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q   <= S_FETCH_T;
            row_q     <= '0;
            col_q     <= '0;
            plane_q   <= '0;
            up_q      <= '0;
            rgb1_q    <= '0;
            rgb2_q    <= '0;
            addr_q    <= '0;
            row_sel_q <= '0;
            pclk_q    <= 1'b0;
            lat_q     <= 1'b0;
            oe_n_q    <= 1'b1;
            fs_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            plane_q   <= plane_d;
            up_q      <= up_d;
            rgb1_q    <= rgb1_d;
            rgb2_q    <= rgb2_d;
            addr_q    <= addr_d;
            row_sel_q <= row_sel_d;
            pclk_q    <= pclk_d;
            lat_q     <= lat_d;
            oe_n_q    <= oe_n_d;
            fs_q      <= fs_d;
        end

    assign pixel_addr                     = addr_q;
    assign {panel_r1, panel_g1, panel_b1} = rgb1_q;
    assign {panel_r2, panel_g2, panel_b2} = rgb2_q;
    assign row_sel                        = row_sel_q;
    assign panel_clk                      = pclk_q;
    assign panel_lat                      = lat_q;
    assign panel_oe_n                     = oe_n_q;
    assign frame_start                    = fs_q;
endmodule
